// File: rtl/cmutex_merge_sync.sv
// cmutex_merge_sync
//   N-channel mutex merge for the cache-replacement control path. Single-cycle
//   drive events from NUM_CH requesters are held in per-channel pending bits.
//   One channel at a time is granted (fixed priority or round-robin). The grant
//   is forwarded downstream as a single drive pulse, and the downstream free is
//   routed back to the granted channel only.
//
// Parameters
//   NUM_CH    number of requesting channels (2..64)
//   ARB_MODE  0 = fixed priority (lowest index wins), 1 = round-robin
//   IDX_W     grant index width, derived from NUM_CH
//
// Ports
//   clk          clock, all state on the rising edge
//   rst          synchronous active-low reset
//   i_drive      per-channel request event (one-cycle pulse)
//   i_freeNext   downstream done (one-cycle pulse, honoured only in WAIT)
//   o_driveNext  one-cycle pulse forwarding the granted request
//   o_free       one-cycle one-hot pulse to the channel whose grant completed
//   o_data       one-hot grant vector, held from DRIVE through WAIT
//   o_grantIdx   binary index of the granted channel, 0 when none
//   o_busy       high in DRIVE and WAIT
//   o_overrun    one-cycle pulse when a drive hit an already-pending channel
module cmutex_merge_sync #(
    parameter int NUM_CH   = 32,
    parameter int ARB_MODE = 1,
    parameter int IDX_W    = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_drive,
    input  logic              i_freeNext,
    output logic              o_driveNext,
    output logic [NUM_CH-1:0] o_free,
    output logic [NUM_CH-1:0] o_data,
    output logic [IDX_W-1:0]  o_grantIdx,
    output logic              o_busy,
    output logic              o_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] pending;
    logic [IDX_W-1:0]  ptr;

    logic              sel_vld;
    logic [IDX_W-1:0]  sel_idx;
    logic [NUM_CH-1:0] sel_onehot;
    logic [IDX_W-1:0]  ptr_next;
    logic [NUM_CH-1:0] clr_mask;

    // Winner search: scan NUM_CH positions starting at base, wrapping at
    // NUM_CH. Fixed priority simply pins the start position to channel 0.
    always_comb begin
        logic [IDX_W-1:0] base;
        logic [IDX_W:0]   pos;
        sel_vld    = 1'b0;
        sel_idx    = '0;
        sel_onehot = '0;
        base       = (ARB_MODE != 0) ? ptr : '0;
        pos        = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = {1'b0, base} + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(NUM_CH)) begin
                pos = pos - (IDX_W+1)'(NUM_CH);
            end
            if (!sel_vld && pending[pos[IDX_W-1:0]]) begin
                sel_vld = 1'b1;
                sel_idx = pos[IDX_W-1:0];
            end
        end
        sel_onehot[sel_idx] = sel_vld;
    end

    // Explicit wrap so non-power-of-two channel counts return to 0.
    assign ptr_next = (sel_idx == IDX_W'(NUM_CH - 1)) ? '0 : sel_idx + IDX_W'(1);

    // A pending bit is only consumed on the IDLE select cycle.
    assign clr_mask = (state == ST_IDLE) ? sel_onehot : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pending     <= '0;
            ptr         <= '0;
            o_driveNext <= 1'b0;
            o_free      <= '0;
            o_data      <= '0;
            o_grantIdx  <= '0;
            o_busy      <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            // A drive landing on the same cycle its bit is consumed re-queues
            // the channel; a drive on a bit that stays set is lost.
            pending     <= (pending & ~clr_mask) | i_drive;
            o_overrun   <= |(i_drive & pending & ~clr_mask);
            o_driveNext <= 1'b0;
            o_free      <= '0;

            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        state       <= ST_DRIVE;
                        o_data      <= sel_onehot;
                        o_grantIdx  <= sel_idx;
                        o_driveNext <= 1'b1;
                        o_busy      <= 1'b1;
                        ptr         <= ptr_next;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_freeNext) begin
                        o_free     <= o_data;
                        o_data     <= '0;
                        o_grantIdx <= '0;
                        o_busy     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmutex_merge_sync.sv
module tb_cmutex_merge_sync;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Round-robin, 32 channels
    logic [31:0] rr_drv = '0;
    logic        rr_fn = 1'b0;
    logic        rr_dn;
    logic [31:0] rr_free, rr_data;
    logic [4:0]  rr_idx;
    logic        rr_busy, rr_ovr;

    // Fixed priority, 32 channels
    logic [31:0] fp_drv = '0;
    logic        fp_fn = 1'b0;
    logic        fp_dn;
    logic [31:0] fp_free, fp_data;
    logic [4:0]  fp_idx;
    logic        fp_busy, fp_ovr;

    // Round-robin, 5 channels
    logic [4:0]  c5_drv = '0;
    logic        c5_fn = 1'b0;
    logic        c5_dn;
    logic [4:0]  c5_free, c5_data;
    logic [2:0]  c5_idx;
    logic        c5_busy, c5_ovr;

    cmutex_merge_sync #(.NUM_CH(32), .ARB_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .i_drive(rr_drv), .i_freeNext(rr_fn),
        .o_driveNext(rr_dn), .o_free(rr_free), .o_data(rr_data),
        .o_grantIdx(rr_idx), .o_busy(rr_busy), .o_overrun(rr_ovr)
    );

    cmutex_merge_sync #(.NUM_CH(32), .ARB_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .i_drive(fp_drv), .i_freeNext(fp_fn),
        .o_driveNext(fp_dn), .o_free(fp_free), .o_data(fp_data),
        .o_grantIdx(fp_idx), .o_busy(fp_busy), .o_overrun(fp_ovr)
    );

    cmutex_merge_sync #(.NUM_CH(5), .ARB_MODE(1)) u_c5 (
        .clk(clk), .rst(rst), .i_drive(c5_drv), .i_freeNext(c5_fn),
        .o_driveNext(c5_dn), .o_free(c5_free), .o_data(c5_data),
        .o_grantIdx(c5_idx), .o_busy(c5_busy), .o_overrun(c5_ovr)
    );

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cross-instance invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("rr_onehot_data", 64'($countones(rr_data) <= 1), 64'd1);
            check("rr_onehot_free", 64'($countones(rr_free) <= 1), 64'd1);
            check("rr_free_vs_drive", 64'(rr_dn && (rr_free != '0)), 64'd0);
            check("fp_busy_vs_data", 64'(fp_busy), 64'(fp_data != '0));
            check("fp_free_vs_drive", 64'(fp_dn && (fp_free != '0)), 64'd0);
            check("c5_busy_vs_data", 64'(c5_busy), 64'(c5_data != '0));
            check("c5_no_overrun", 64'(c5_ovr), 64'd0);
        end
    end

    typedef struct {
        logic        rst;
        logic [31:0] drv;
        logic        fn;
        logic        dn;
        logic [31:0] data;
        logic [4:0]  idx;
        logic [31:0] free;
        logic        busy;
        logic        ovr;
    } vec_t;

    vec_t tbl[$];

    // Expect all outputs idle.
    function automatic vec_t Z(input logic r, input logic [31:0] d, input logic f);
        vec_t v;
        v.rst = r; v.drv = d; v.fn = f;
        v.dn = 1'b0; v.data = '0; v.idx = '0; v.free = '0; v.busy = 1'b0; v.ovr = 1'b0;
        return v;
    endfunction

    // Expect channel g granted (DRIVE when n=1, WAIT when n=0).
    function automatic vec_t G(input logic [31:0] d, input logic f, input logic n,
                               input int g, input logic o);
        vec_t v;
        v.rst = 1'b1; v.drv = d; v.fn = f;
        v.dn = n; v.data = 32'h1 << g; v.idx = 5'(g); v.free = '0; v.busy = 1'b1; v.ovr = o;
        return v;
    endfunction

    // Expect free pulse to channel g, grant cleared.
    function automatic vec_t F(input logic [31:0] d, input logic f, input int g);
        vec_t v;
        v.rst = 1'b1; v.drv = d; v.fn = f;
        v.dn = 1'b0; v.data = '0; v.idx = '0; v.free = 32'h1 << g; v.busy = 1'b0; v.ovr = 1'b0;
        return v;
    endfunction

    task automatic serve5(input int exp_idx);
        int n = 0;
        while (c5_dn !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("c5_grant_seen", 64'(c5_dn), 64'd1);
        check("c5_grant_idx", 64'(c5_idx), 64'(exp_idx));
        @(negedge clk);
        @(posedge clk);
        @(negedge clk); c5_fn = 1'b1;
        @(posedge clk); #1;
        check("c5_free", 64'(c5_free), 64'(5'b1 << exp_idx));
        @(negedge clk); c5_fn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int g0, nine, ovr_cnt;
        logic seen9;

        // Reset and single request on 5, free ignored in DRIVE and IDLE
        repeat (3) tbl.push_back(Z(1'b0, 32'h0, 1'b0));
        tbl.push_back(Z(1'b1, 32'h20, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 5, 1'b0));
        tbl.push_back(G(32'h0, 1'b1, 1'b0, 5, 1'b0));
        repeat (3) tbl.push_back(G(32'h0, 1'b0, 1'b0, 5, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 5));
        tbl.push_back(Z(1'b1, 32'h0, 1'b1));
        tbl.push_back(Z(1'b1, 32'h0, 1'b0));
        // Round-robin 3, 7, 31 then 3, 7 again
        tbl.push_back(Z(1'b0, 32'h0, 1'b0));
        tbl.push_back(Z(1'b1, 32'h8000_0088, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 3, 1'b0));
        repeat (2) tbl.push_back(G(32'h0, 1'b0, 1'b0, 3, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 3));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 7, 1'b0));
        repeat (2) tbl.push_back(G(32'h0, 1'b0, 1'b0, 7, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 7));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 31, 1'b0));
        tbl.push_back(G(32'h88, 1'b0, 1'b0, 31, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b0, 31, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 31));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 3, 1'b0));
        repeat (2) tbl.push_back(G(32'h0, 1'b0, 1'b0, 3, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 3));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 7, 1'b0));
        repeat (2) tbl.push_back(G(32'h0, 1'b0, 1'b0, 7, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 7));
        tbl.push_back(Z(1'b1, 32'h0, 1'b0));
        // Drive on own select cycle re-queues; double drive while pending overruns
        tbl.push_back(Z(1'b1, 32'h10, 1'b0));
        tbl.push_back(G(32'h10, 1'b0, 1'b1, 4, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b0, 4, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 4));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 4, 1'b0));
        tbl.push_back(G(32'h10, 1'b0, 1'b0, 4, 1'b0));
        tbl.push_back(G(32'h10, 1'b0, 1'b0, 4, 1'b1));
        tbl.push_back(G(32'h0, 1'b0, 1'b0, 4, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 4));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 4, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b0, 4, 1'b0));
        tbl.push_back(F(32'h0, 1'b1, 4));
        repeat (2) tbl.push_back(Z(1'b1, 32'h0, 1'b0));
        // Reset in WAIT with grant 12 and channel 2 pending
        tbl.push_back(Z(1'b1, 32'h1000, 1'b0));
        tbl.push_back(G(32'h0, 1'b0, 1'b1, 12, 1'b0));
        tbl.push_back(G(32'h4, 1'b0, 1'b0, 12, 1'b0));
        tbl.push_back(Z(1'b0, 32'h0, 1'b0));
        repeat (3) tbl.push_back(Z(1'b1, 32'h0, 1'b0));

        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            rst    = tbl[r].rst;
            rr_drv = tbl[r].drv;
            rr_fn  = tbl[r].fn;
            @(posedge clk); #1;
            mon_en = 1'b1;
            check($sformatf("row%0d_driveNext", r), 64'(rr_dn),   64'(tbl[r].dn));
            check($sformatf("row%0d_data", r),      64'(rr_data), 64'(tbl[r].data));
            check($sformatf("row%0d_grantIdx", r),  64'(rr_idx),  64'(tbl[r].idx));
            check($sformatf("row%0d_free", r),      64'(rr_free), 64'(tbl[r].free));
            check($sformatf("row%0d_busy", r),      64'(rr_busy), 64'(tbl[r].busy));
            check($sformatf("row%0d_overrun", r),   64'(rr_ovr),  64'(tbl[r].ovr));
        end

        // Fixed priority: channels 0 and 9 re-driven every cycle
        @(negedge clk); rst = 1'b0; rr_drv = '0; rr_fn = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        g0 = 0; nine = 0; ovr_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            fp_drv = 32'h201;
            fp_fn  = fp_busy & ~fp_dn;
            @(posedge clk); #1;
            if (fp_dn) begin
                g0++;
                check("fp_grant_ch0", 64'(fp_idx), 64'd0);
            end
            if (fp_data[9]) nine++;
            if (fp_ovr) ovr_cnt++;
        end
        check("fp_ch9_never_granted", 64'(nine), 64'd0);
        check("fp_ch0_grants_ge5", 64'(g0 >= 5), 64'd1);
        check("fp_overrun_seen", 64'(ovr_cnt > 0), 64'd1);
        seen9 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            fp_drv = '0;
            fp_fn  = fp_busy & ~fp_dn;
            @(posedge clk); #1;
            if (fp_dn && fp_idx == 5'd9) seen9 = 1'b1;
        end
        check("fp_ch9_after_release", 64'(seen9), 64'd1);
        @(negedge clk); fp_fn = 1'b0;

        // 5-channel round-robin: all five, then wrap 4 -> 0
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); c5_drv = 5'h1F;
        @(posedge clk); #1;
        @(negedge clk); c5_drv = 5'h00;
        for (int ch = 0; ch < 5; ch++) serve5(ch);
        @(negedge clk); c5_drv = 5'h02;
        @(posedge clk); #1;
        @(negedge clk); c5_drv = 5'h00;
        serve5(1);
        @(negedge clk); c5_drv = 5'h11;
        @(posedge clk); #1;
        @(negedge clk); c5_drv = 5'h00;
        serve5(4);
        serve5(0);
        repeat (3) @(posedge clk);
        #1;
        check("c5_idle_at_end", 64'(c5_busy), 64'd0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmutex_merge_sync.md
# cmutex_merge_sync

Synchronous, parametrised N-channel mutex merge for the cache-replacement control path. It collects single-cycle drive events from `NUM_CH` requesters and holds each in a per-channel pending latch. It grants exactly one channel at a time, by fixed-priority or round-robin arbitration, and forwards a single drive pulse downstream. When the downstream free arrives, it returns a free pulse to the granted channel only. Drive events from all channels remain accepted while a grant is outstanding.

## Interface
Parameters:
- `NUM_CH`, 32, number of requesting channels (2..64)
- `ARB_MODE`, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- `IDX_W`, `$clog2(NUM_CH)`, width of the grant index (derived, do not override)

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-low reset
- `i_drive`  in  NUM_CH  per-channel request event, one-cycle pulse
- `i_freeNext`  in  1  downstream done, one-cycle pulse
- `o_driveNext`  out  1  one-cycle pulse, granted request forwarded downstream
- `o_free`  out  NUM_CH  one-cycle pulse to the channel whose grant completed
- `o_data`  out  NUM_CH  one-hot grant vector, stable from DRIVE through WAIT; zero otherwise
- `o_grantIdx`  out  IDX_W  binary index of the granted channel; 0 when none
- `o_busy`  out  1  high in DRIVE and WAIT
- `o_overrun`  out  1  one-cycle pulse when a drive hits an already-pending channel

## Operation
- `pending[i]` is set by `i_drive[i]` and cleared when channel i is selected.
- If a drive arrives on the cycle its own pending bit is cleared by selection, the bit stays set; the new request queues.
- If a drive arrives while `pending[i]` is already set and not being cleared, the event is dropped and `o_overrun` pulses next cycle.
- State machine:
  - IDLE: if any pending bit is set, select a winner, load the grant registers, clear that pending bit, go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: `o_driveNext` is 1 for this single cycle. Go to WAIT unconditionally. `i_freeNext` is ignored in this state.
  - WAIT: on `i_freeNext`=1, pulse `o_free[grant]`, clear `o_data` and `o_grantIdx`, and go to IDLE. Otherwise hold.
- `i_freeNext` in IDLE or DRIVE is ignored, with no side effects.
- Fixed priority (`ARB_MODE`=0): the lowest set pending index wins.
- Round-robin (`ARB_MODE`=1):
  - Search starts at `ptr` and wraps from `NUM_CH-1` to 0.
  - After each selection, `ptr` = winner+1 mod `NUM_CH`.
  - `ptr` resets to 0.
- Drives to the currently granted channel during WAIT set its pending bit normally and are served by a later grant.
- Reset:
  - Clears pending, grant, `ptr`, and state to IDLE.
  - All outputs go to 0 at the first edge with `rst`=0.
  - Reset during DRIVE or WAIT drops the outstanding grant; no `o_free` is emitted for it.

## Timing
- All outputs are registered.
- `i_drive[i]` high in cycle 0 gives `pending[i]` in cycle 1, and grant plus `o_driveNext` in cycle 2 if the block was idle.
- `i_freeNext` high in cycle k (in WAIT) gives `o_free` in cycle k+1, with the block in IDLE in cycle k+1. The next grant and `o_driveNext` follow in cycle k+2.
- Minimum spacing between consecutive `o_driveNext` pulses is 3 cycles: DRIVE, WAIT with free, IDLE select.
- At most one bit of `o_data` is ever set. At most one bit of `o_free` is ever set.
- `o_free` is never asserted in the same cycle as `o_driveNext`.

## Test plan
- Reset and single request:
  - Hold `rst`=0 for 3 cycles: all outputs 0.
  - Release, pulse `i_drive[5]` at cycle 0: `o_driveNext` at cycle 2, `o_data`=32'h20, `o_grantIdx`=5.
  - Pulse `i_freeNext` at cycle 6: `o_free`=32'h20 at cycle 7, `o_data`=0.
- Round-robin order (`ARB_MODE`=1):
  - Pulse drives on channels 3, 7 and 31 in the same cycle, and ack each grant 2 cycles after its `o_driveNext`.
  - Grants must be 3, 7, 31.
  - Then re-drive 3 and 7 together: 7 is never granted twice before 3. Next grant is 3 (`ptr`=0 after 31).
- Fixed priority (`ARB_MODE`=0):
  - Keep channels 0 and 9 permanently re-driven.
  - Channel 0 wins every arbitration; channel 9 is never granted while 0 is pending.
- Simultaneous and overrun:
  - Drive channel 4 on its own selection cycle: pending stays set, a second grant to 4 follows, and `o_overrun`=0.
  - Drive 4 twice while pending: `o_overrun` pulses once, and only one grant results.
- Protocol edge cases:
  - `i_freeNext` during IDLE and during DRIVE: no `o_free`, and the state is unchanged.
  - Assert `rst` in WAIT with grant 12 and a pending bit on 2: all cleared, no `o_free[12]`, and no grant to 2 after release.
- `NUM_CH`=5 build:
  - Wrap-around from channel 4 to 0 under round-robin.
  - `o_grantIdx` width is 3, and all five channels are granted.
